// File: rtl/img_rsz.sv
// -----------------------------------------------------------------------------
// img_rsz -- streaming block-average image down-scaler.
//
// Input pixels arrive in raster order for a frame of ImgWidth x ImgHeight.
// Every pixel is added into one of RSZ_H x RSZ_W block accumulators. The
// accumulator is picked by bx = floor(x*RSZ_W/ImgWidth) and
// by = floor(y*RSZ_H/ImgHeight), both tracked incrementally so that no divider
// is needed on the input path. After the last pixel of the frame, each block
// average floor(sum/count) is computed by a restoring divider, one block at a
// time in raster order, and then presented on the output handshake.
//
// Handshakes: a transfer happens on a rising Clk edge where valid && ready.
// A source holds valid and its payload stable until that edge; ready may
// change freely. PxlRdy is only high in ACCUM; RszPxlVld only in OUT.
//
// Ports:
//   Clk, Reset        clock (rising edge) and async active-low reset
//   ImgWidth/Height   input frame size, stable for the whole frame
//   PxlData/X/Y       input pixel (unpacked colours) and its coordinates
//   PxlVld/PxlRdy     input handshake
//   RszPxlData/X/Y    averaged output pixel and its block coordinates
//   RszPxlVld/Rdy     output handshake
//   FcRszPxlBuf       live per-block colour sums
//   RszPxlParVld      per-block "all pixels received" flags
// -----------------------------------------------------------------------------
package ImgRszPkg;
  localparam int PXL_PRIM_COLOR_W     = 8;
  localparam int PXL_PRIM_COLOR_NUM   = 3;
  localparam int IMG_WIDTH_IDX_W      = 10;
  localparam int IMG_HEIGHT_IDX_W     = 10;
  localparam int RSZ_IMG_WIDTH_SIZE   = 4;
  localparam int RSZ_IMG_HEIGHT_SIZE  = 4;
  localparam int RSZ_IMG_WIDTH_IDX_W  = 2;
  localparam int RSZ_IMG_HEIGHT_IDX_W = 2;
  localparam int RSZ_SUM_W            = 24;
  localparam int RSZ_CNT_W            = 17;

  typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] FcRszPxlData_t;
  typedef logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0]
                [PXL_PRIM_COLOR_NUM-1:0][RSZ_SUM_W-1:0] FcRszPxlBuf_t;
endpackage

module img_rsz
  import ImgRszPkg::*;
(
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic [IMG_WIDTH_IDX_W-1:0]      ImgWidth,
  input  logic [IMG_HEIGHT_IDX_W-1:0]     ImgHeight,
  input  logic [PXL_PRIM_COLOR_W-1:0]     PxlData [PXL_PRIM_COLOR_NUM],
  input  logic [IMG_WIDTH_IDX_W-1:0]      PxlX,
  input  logic [IMG_HEIGHT_IDX_W-1:0]     PxlY,
  input  logic                            PxlVld,
  output logic                            PxlRdy,
  output FcRszPxlData_t                   RszPxlData,
  output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  RszPxlX,
  output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RszPxlY,
  output logic                            RszPxlVld,
  input  logic                            RszPxlRdy,
  output FcRszPxlBuf_t                    FcRszPxlBuf,
  output logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0] RszPxlParVld
);

  localparam int EX_W      = IMG_WIDTH_IDX_W + 1;
  localparam int EY_W      = IMG_HEIGHT_IDX_W + 1;
  localparam int K_W       = RSZ_IMG_WIDTH_IDX_W + RSZ_IMG_HEIGHT_IDX_W;
  localparam int DIV_CNT_W = $clog2(RSZ_SUM_W);

  localparam logic [K_W-1:0]       K_LAST   = K_W'(RSZ_IMG_WIDTH_SIZE * RSZ_IMG_HEIGHT_SIZE - 1);
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(RSZ_SUM_W - 1);
  localparam logic [EX_W-1:0]      STEP_X   = EX_W'(RSZ_IMG_WIDTH_SIZE);
  localparam logic [EY_W-1:0]      STEP_Y   = EY_W'(RSZ_IMG_HEIGHT_SIZE);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state, state_nx;

  // PxlRdy stays low until the first edge after reset release.
  logic rdy_armed;

  logic in_fire, out_fire, frame_last, clear_all, blk_last;

  // Incremental block mapping: *_q hold the previous accepted pixel's values.
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  bx_q, bx_cur;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] by_q, by_cur;
  logic [EX_W-1:0]                 ex_q, ex_cur, ex_step;
  logic [EY_W-1:0]                 ey_q, ey_cur, ey_step;

  logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0][RSZ_CNT_W-1:0] blk_cnt;

  // Output block index, raster order with X in the low bits.
  logic [K_W-1:0]                  k;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  k_x;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] k_y;

  // Restoring divider, one lane per colour. The quotient is known to fit in
  // a pixel (an average of pixels), so only its low bits are kept.
  logic [DIV_CNT_W-1:0]                                  div_cnt, bit_idx;
  logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_CNT_W-1:0]          rem, rem_nx;
  logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_CNT_W:0]            rem_sh;
  logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-2:0]   quo;
  logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]   quo_nx;
  logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_SUM_W-1:0]          sum_sel;
  logic [RSZ_CNT_W-1:0]                                  cnt_sel;

  assign in_fire    = PxlVld && rdy_armed && (state == ACCUM);
  assign out_fire   = RszPxlRdy && (state == OUT);
  assign clear_all  = out_fire && (k == K_LAST);
  assign frame_last = (PxlX == ImgWidth - IMG_WIDTH_IDX_W'(1)) &&
                      (PxlY == ImgHeight - IMG_HEIGHT_IDX_W'(1));
  assign k_x = k[RSZ_IMG_WIDTH_IDX_W-1:0];
  assign k_y = k[K_W-1:RSZ_IMG_WIDTH_IDX_W];

  // ---------------------------------------------------------------------------
  // Block column/row of the pixel currently offered.
  // ex tracks (x*RSZ_W) mod ImgWidth; bx steps each time it wraps.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_step = ex_q + STEP_X;
    bx_cur  = bx_q;
    ex_cur  = ex_step;
    if (PxlX == '0) begin
      bx_cur = '0;
      ex_cur = '0;
    end else if (ex_step >= {1'b0, ImgWidth}) begin
      bx_cur = bx_q + 1'b1;
      ex_cur = ex_step - {1'b0, ImgWidth};
    end
  end

  // The row mapping only advances at the first pixel of each new row.
  always_comb begin
    ey_step = ey_q + STEP_Y;
    by_cur  = by_q;
    ey_cur  = ey_q;
    if (PxlX == '0) begin
      if (PxlY == '0) begin
        by_cur = '0;
        ey_cur = '0;
      end else if (ey_step >= {1'b0, ImgHeight}) begin
        by_cur = by_q + 1'b1;
        ey_cur = ey_step - {1'b0, ImgHeight};
      end else begin
        ey_cur = ey_step;
      end
    end
  end

  // A pixel is the last of its block when the next column (and next row)
  // would map to a different block, or it sits on the frame edge.
  assign blk_last =
    ((PxlX == ImgWidth - IMG_WIDTH_IDX_W'(1)) || ((ex_cur + STEP_X) >= {1'b0, ImgWidth})) &&
    ((PxlY == ImgHeight - IMG_HEIGHT_IDX_W'(1)) || ((ey_cur + STEP_Y) >= {1'b0, ImgHeight}));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ACCUM;
      rdy_armed <= 1'b0;
    end else begin
      state     <= state_nx;
      rdy_armed <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    PxlRdy    = 1'b0;
    RszPxlVld = 1'b0;
    case (state)
      ACCUM: begin
        PxlRdy = rdy_armed;
        if (in_fire && frame_last) state_nx = DIV;
      end
      DIV: begin
        if (div_cnt == DIV_LAST) state_nx = OUT;
      end
      OUT: begin
        RszPxlVld = 1'b1;
        if (RszPxlRdy) state_nx = (k == K_LAST) ? ACCUM : DIV;
      end
      default: state_nx = ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulation
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      FcRszPxlBuf  <= '0;
      blk_cnt      <= '0;
      RszPxlParVld <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      ex_q         <= '0;
      ey_q         <= '0;
    end else if (clear_all) begin
      FcRszPxlBuf  <= '0;
      blk_cnt      <= '0;
      RszPxlParVld <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      ex_q         <= '0;
      ey_q         <= '0;
    end else if (in_fire) begin
      for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
        FcRszPxlBuf[by_cur][bx_cur][c] <= FcRszPxlBuf[by_cur][bx_cur][c] +
                                          RSZ_SUM_W'(PxlData[c]);
      end
      blk_cnt[by_cur][bx_cur] <= blk_cnt[by_cur][bx_cur] + 1'b1;
      if (blk_last) RszPxlParVld[by_cur][bx_cur] <= 1'b1;
      bx_q <= bx_cur;
      by_q <= by_cur;
      ex_q <= ex_cur;
      ey_q <= ey_cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider: the dividend bits are read straight from the (frozen) sum of
  // block k, MSB first, so no dividend copy is needed.
  // ---------------------------------------------------------------------------
  always_comb begin
    sum_sel = FcRszPxlBuf[k_y][k_x];
    cnt_sel = blk_cnt[k_y][k_x];
    bit_idx = DIV_LAST - div_cnt;
    rem_sh  = '0;
    rem_nx  = '0;
    quo_nx  = '0;
    for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
      rem_sh[c] = {rem[c], sum_sel[c][bit_idx]};
      if (rem_sh[c] >= {1'b0, cnt_sel}) begin
        rem_nx[c] = RSZ_CNT_W'(rem_sh[c] - {1'b0, cnt_sel});
        quo_nx[c] = {quo[c], 1'b1};
      end else begin
        rem_nx[c] = rem_sh[c][RSZ_CNT_W-1:0];
        quo_nx[c] = {quo[c], 1'b0};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_cnt <= '0;
      rem     <= '0;
      quo     <= '0;
    end else if (state != DIV) begin
      div_cnt <= '0;
      rem     <= '0;
      quo     <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      rem     <= rem_nx;
      for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
        quo[c] <= quo_nx[c][PXL_PRIM_COLOR_W-2:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and block index
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RszPxlData <= '0;
      RszPxlX    <= '0;
      RszPxlY    <= '0;
      k          <= '0;
    end else begin
      if ((state == DIV) && (div_cnt == DIV_LAST)) begin
        for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
          // An empty block would divide by zero; report black instead.
          RszPxlData[c] <= (cnt_sel == '0) ? '0 : quo_nx[c];
        end
        RszPxlX <= k_x;
        RszPxlY <= k_y;
      end
      if (out_fire) k <= (k == K_LAST) ? '0 : k + 1'b1;
    end
  end

endmodule

// File: tb/tb_img_rsz.sv
// -----------------------------------------------------------------------------
// tb_img_rsz -- self-checking bench for img_rsz.
// A table of frame cases is replayed; for each frame a block-average model
// computed directly from the pixel array fills exp_q, and every output
// transfer is compared against it. Hand-written sequences cover reset,
// output back-pressure and a mid-frame reset.
// -----------------------------------------------------------------------------
module tb_img_rsz;
  import ImgRszPkg::*;

  localparam int MAXP = 129 * 65;

  typedef logic [27:0] out_t;  // {y[1:0], x[1:0], d2, d1, d0}

  typedef struct {
    int w;
    int h;
    int mode;    // 0: d0 = x, 1: constant val, 2: random
    int val;
    int in_b;
    int out_b;
    int reps;
    int row0;
  } vec_t;

  // ---------------------------------------------------------------- clock/reset
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic [IMG_WIDTH_IDX_W-1:0]      ImgWidth = '0;
  logic [IMG_HEIGHT_IDX_W-1:0]     ImgHeight = '0;
  logic [PXL_PRIM_COLOR_W-1:0]     PxlData [PXL_PRIM_COLOR_NUM];
  logic [IMG_WIDTH_IDX_W-1:0]      PxlX = '0;
  logic [IMG_HEIGHT_IDX_W-1:0]     PxlY = '0;
  logic                            PxlVld = 1'b0;
  logic                            PxlRdy;
  FcRszPxlData_t                   RszPxlData;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  RszPxlX;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RszPxlY;
  logic                            RszPxlVld;
  logic                            RszPxlRdy;
  FcRszPxlBuf_t                    FcRszPxlBuf;
  logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0] RszPxlParVld;

  img_rsz dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ImgWidth     (ImgWidth),
    .ImgHeight    (ImgHeight),
    .PxlData      (PxlData),
    .PxlX         (PxlX),
    .PxlY         (PxlY),
    .PxlVld       (PxlVld),
    .PxlRdy       (PxlRdy),
    .RszPxlData   (RszPxlData),
    .RszPxlX      (RszPxlX),
    .RszPxlY      (RszPxlY),
    .RszPxlVld    (RszPxlVld),
    .RszPxlRdy    (RszPxlRdy),
    .FcRszPxlBuf  (FcRszPxlBuf),
    .RszPxlParVld (RszPxlParVld)
  );

  // ---------------------------------------------------------------- scoreboard
  out_t exp_q[$];
  out_t got_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   out_b    = 0;
  bit   hold_rdy_low = 1'b0;
  logic [7:0] frame_mem [MAXP][3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout, got no event expected one at %0t", name, $time);
    report_and_finish();
  endtask

  // Output side: drives RszPxlRdy and scores every transfer.
  initial begin
    out_t got, e;
    RszPxlRdy = 1'b0;
    forever begin
      @(negedge Clk);
      if (hold_rdy_low) RszPxlRdy = 1'b0;
      else if (out_b == 0) RszPxlRdy = 1'b1;
      else RszPxlRdy = ($urandom_range(0, out_b) == 0);
      if (Reset && RszPxlVld && RszPxlRdy) begin
        got = {RszPxlY, RszPxlX, RszPxlData};
        got_q.push_back(got);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_extra: got %0h expected none", got);
        end else begin
          e = exp_q.pop_front();
          check("out_pixel", got, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------- model
  task automatic fill_frame(input int w, input int h, input int mode, input int val);
    for (int i = 0; i < w * h; i++) begin
      for (int c = 0; c < 3; c++) begin
        case (mode)
          0:       frame_mem[i][c] = (c == 0) ? 8'(i % w) : 8'd0;
          1:       frame_mem[i][c] = 8'(val);
          default: frame_mem[i][c] = 8'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  // Block averages straight from the definition: floor(x*4/w), floor(y*4/h).
  task automatic push_model(input int w, input int h);
    int   sum [4][4][3];
    int   cnt [4][4];
    out_t e;
    for (int by = 0; by < 4; by++)
      for (int bx = 0; bx < 4; bx++) begin
        cnt[by][bx] = 0;
        for (int c = 0; c < 3; c++) sum[by][bx][c] = 0;
      end
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        int bx, by;
        bx = (x * RSZ_IMG_WIDTH_SIZE) / w;
        by = (y * RSZ_IMG_HEIGHT_SIZE) / h;
        cnt[by][bx]++;
        for (int c = 0; c < 3; c++) sum[by][bx][c] += int'(frame_mem[y * w + x][c]);
      end
    for (int by = 0; by < 4; by++)
      for (int bx = 0; bx < 4; bx++) begin
        e = '0;
        e[27:26] = 2'(by);
        e[25:24] = 2'(bx);
        for (int c = 0; c < 3; c++)
          e[c*8 +: 8] = (cnt[by][bx] == 0) ? 8'd0 : 8'(sum[by][bx][c] / cnt[by][bx]);
        exp_q.push_back(e);
      end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic send_frame(input int w, input int h, input int in_b,
                            input int limit, input int row0);
    ImgWidth  = IMG_WIDTH_IDX_W'(w);
    ImgHeight = IMG_HEIGHT_IDX_W'(h);
    for (int i = 0; i < w * h; i++) begin
      int nb, wcnt;
      if (i == limit) break;
      if (row0 != 0 && i == w) begin
        // Row 0 is fully absorbed; check its block sums and column boundaries.
        @(negedge Clk);
        PxlVld = 1'b0;
        for (int bx = 0; bx < 4; bx++) begin
          int s;
          s = 0;
          for (int x = 0; x < w; x++)
            if ((x * RSZ_IMG_WIDTH_SIZE) / w == bx) s += int'(frame_mem[x][0]);
          check("row0_block_sum", 64'(FcRszPxlBuf[0][bx][0]), 64'(s));
        end
        check("row0_blk00_528", 64'(FcRszPxlBuf[0][0][0]), 64'd528);
      end
      nb = $urandom_range(0, in_b);
      repeat (nb) begin
        @(negedge Clk);
        PxlVld = 1'b0;
      end
      @(negedge Clk);
      PxlVld = 1'b1;
      PxlX   = IMG_WIDTH_IDX_W'(i % w);
      PxlY   = IMG_HEIGHT_IDX_W'(i / w);
      for (int c = 0; c < 3; c++) PxlData[c] = frame_mem[i][c];
      wcnt = 0;
      while (!PxlRdy) begin
        @(negedge Clk);
        wcnt++;
        if (wcnt > 3000) timeout_fail("pxl_rdy_wait");
      end
    end
    @(negedge Clk);
    PxlVld = 1'b0;
  endtask

  task automatic wait_out_vld();
    int wcnt;
    wcnt = 0;
    while (!RszPxlVld) begin
      @(negedge Clk);
      wcnt++;
      if (wcnt > 3000) timeout_fail("rsz_vld_wait");
    end
  endtask

  task automatic drain();
    int wcnt;
    wcnt = 0;
    while (exp_q.size() != 0) begin
      @(negedge Clk);
      wcnt++;
      if (wcnt > 20000) timeout_fail("drain");
    end
    repeat (2) @(negedge Clk);
  endtask

  // Hand-derived expectations for the structured patterns.
  task automatic hand_check(input int mode, input int val, input int n);
    int   xcol [4];
    int   base;
    out_t g;
    xcol = '{16, 48, 80, 112};
    base = got_q.size() - n;
    for (int j = 0; j < n; j++) begin
      g = got_q[base + j];
      check("hand_raster_idx", 64'(g[27:24]), 64'(j % 16));
      if (mode == 0) begin
        check("hand_xpat_d0", 64'(g[7:0]), 64'(xcol[j % 4]));
        check("hand_xpat_d12", 64'(g[23:8]), 64'd0);
      end else begin
        check("hand_const_d0", 64'(g[7:0]), 64'(val));
        check("hand_const_d12", 64'(g[23:8]), 64'({8'(val), 8'(val)}));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pxl_rdy"}, 64'(PxlRdy), 64'd0);
    check({tag, "_rsz_vld"}, 64'(RszPxlVld), 64'd0);
    check({tag, "_rsz_data"}, 64'({RszPxlY, RszPxlX, RszPxlData}), 64'd0);
    check({tag, "_par_vld"}, 64'(RszPxlParVld), 64'd0);
    check({tag, "_buf_nonzero"}, 64'(FcRszPxlBuf != '0), 64'd0);
  endtask

  // ---------------------------------------------------------------- test
  vec_t vecs [6];

  initial begin
    vecs[0] = '{w: 129, h: 65, mode: 0, val: 0,   in_b: 0, out_b: 0, reps: 1, row0: 1};
    vecs[1] = '{w: 129, h: 65, mode: 2, val: 0,   in_b: 2, out_b: 2, reps: 2, row0: 0};
    vecs[2] = '{w: 4,   h: 4,  mode: 1, val: 200, in_b: 0, out_b: 0, reps: 1, row0: 0};
    vecs[3] = '{w: 37,  h: 23, mode: 2, val: 0,   in_b: 1, out_b: 1, reps: 1, row0: 0};
    vecs[4] = '{w: 5,   h: 4,  mode: 2, val: 0,   in_b: 0, out_b: 2, reps: 1, row0: 0};
    vecs[5] = '{w: 4,   h: 9,  mode: 1, val: 77,  in_b: 2, out_b: 0, reps: 1, row0: 0};
    for (int c = 0; c < 3; c++) PxlData[c] = '0;

    // Power-on reset and PxlRdy release timing.
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_state("por");
    Reset = 1'b1;
    check("por_rdy_before_edge", 64'(PxlRdy), 64'd0);
    @(negedge Clk);
    check("por_rdy_after_edge", 64'(PxlRdy), 64'd1);

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      out_b = vecs[v].out_b;
      fill_frame(vecs[v].w, vecs[v].h, vecs[v].mode, vecs[v].val);
      for (int r = 0; r < vecs[v].reps; r++) begin
        push_model(vecs[v].w, vecs[v].h);
        send_frame(vecs[v].w, vecs[v].h, vecs[v].in_b, -1, (r == 0) ? vecs[v].row0 : 0);
        wait_out_vld();
        check("par_vld_all_at_first_out", 64'(RszPxlParVld), 64'hFFFF);
        check("pxl_rdy_low_in_out", 64'(PxlRdy), 64'd0);
      end
      drain();
      if (vecs[v].mode != 2) hand_check(vecs[v].mode, vecs[v].val, 16 * vecs[v].reps);
    end

    // Output back-pressure: 50 stalled cycles must freeze the output.
    begin
      bit vld_bad, data_bad, rdy_bad;
      out_b = 0;
      fill_frame(6, 6, 2, 0);
      push_model(6, 6);
      hold_rdy_low = 1'b1;
      send_frame(6, 6, 0, -1, 0);
      wait_out_vld();
      vld_bad = 1'b0;
      data_bad = 1'b0;
      rdy_bad = 1'b0;
      repeat (50) begin
        @(negedge Clk);
        if (RszPxlVld !== 1'b1) vld_bad = 1'b1;
        if ({RszPxlY, RszPxlX, RszPxlData} !== exp_q[0]) data_bad = 1'b1;
        if (PxlRdy !== 1'b0) rdy_bad = 1'b1;
      end
      check("stall_vld_dropped", 64'(vld_bad), 64'd0);
      check("stall_data_changed", 64'(data_bad), 64'd0);
      check("stall_pxl_rdy_high", 64'(rdy_bad), 64'd0);
      hold_rdy_low = 1'b0;
      drain();
    end

    // Mid-frame reset, then a clean 8x8 frame of value 10.
    fill_frame(8, 8, 1, 250);
    send_frame(8, 8, 0, 40, 0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_reset_state("mid_rst");
    @(negedge Clk);
    Reset = 1'b1;
    check("mid_rst_rdy_before_edge", 64'(PxlRdy), 64'd0);
    @(negedge Clk);
    check("mid_rst_rdy_after_edge", 64'(PxlRdy), 64'd1);
    fill_frame(8, 8, 1, 10);
    push_model(8, 8);
    send_frame(8, 8, 1, -1, 0);
    wait_out_vld();
    check("rst_frame_par_vld", 64'(RszPxlParVld), 64'hFFFF);
    drain();
    hand_check(1, 10, 16);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    report_and_finish();
  end

endmodule
